// File: rtl/alu_pkg.sv
// Shared types for the ALU datapath and its downstream consumers.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // One captured ALU response, tagged with the opcode that produced it.
    typedef struct packed {
        logic [1:0] op;
        logic       carry;
        logic       zero;
        logic [3:0] result;
    } alu_resp_t;

endpackage

// File: rtl/alu_result_buffer_if.sv
// Producer/consumer bundle for the ALU result buffer.
interface alu_result_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [3:0]    in_result;
    logic          in_carry;
    logic          in_zero;

    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_op;
    logic [3:0]    out_result;
    logic          out_carry;
    logic          out_zero;

    logic [CW-1:0] count;
    logic          sticky_carry;
    logic          sticky_zero;
    logic          clear_sticky;
    logic [7:0]    accepted;

    // Controller / ALU side
    modport master (
        output in_valid, in_op, in_result, in_carry, in_zero,
        output out_ready, clear_sticky,
        input  in_ready, out_valid, out_op, out_result, out_carry, out_zero,
        input  count, sticky_carry, sticky_zero, accepted
    );

    // Buffer side
    modport slave (
        input  in_valid, in_op, in_result, in_carry, in_zero,
        input  out_ready, clear_sticky,
        output in_ready, out_valid, out_op, out_result, out_carry, out_zero,
        output count, sticky_carry, sticky_zero, accepted
    );

endinterface

// File: rtl/alu_result_buffer.sv
// Registered FIFO stage behind the 4-bit ALU, with sticky status flags and
// an accepted-operation counter that can be polled without draining.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_result_buffer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    alu_resp_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              sticky_c;
    logic              sticky_z;
    logic [7:0]        acc_cnt;
    logic              push;
    logic              pop;
    alu_resp_t         head;

    // Handshake status comes only from registered occupancy; no full
    // pass-through and no empty bypass.
    always_comb begin
        bus.in_ready  = (cnt < FULL);
        bus.out_valid = (cnt != '0);
        push          = bus.in_valid && (cnt < FULL);
        pop           = bus.out_ready && (cnt != '0);
        head          = mem[rd_ptr];
    end

    assign bus.out_op       = head.op;
    assign bus.out_result   = head.result;
    assign bus.out_carry    = head.carry;
    assign bus.out_zero     = head.zero;
    assign bus.count        = cnt;
    assign bus.sticky_carry = sticky_c;
    assign bus.sticky_zero  = sticky_z;
    assign bus.accepted     = acc_cnt;

    // Storage; cleared on reset so an empty buffer never shows X.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{op: bus.in_op, carry: bus.in_carry,
                             zero: bus.in_zero, result: bus.in_result};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: unchanged when push and pop coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (push && !pop) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !push) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Sticky flags; a new event in the clear cycle is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_c <= 1'b0;
            sticky_z <= 1'b0;
        end else begin
            sticky_c <= (sticky_c & ~bus.clear_sticky) | (push & bus.in_carry);
            sticky_z <= (sticky_z & ~bus.clear_sticky) | (push & bus.in_zero);
        end
    end

    // Accepted-operation counter, wraps at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt <= '0;
        end else if (push) begin
            acc_cnt <= acc_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed vector table, spec corner sequences
// and randomized traffic against a queue-based reference model.
module tb_alu_result_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_result_buffer_if #(.DEPTH(DEPTH)) bus ();

    alu_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queue of {op, carry, zero, result}
    logic [7:0] mq[$];
    logic       m_sc;
    logic       m_sz;
    int         m_acc;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [1:0] op;
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       ordy;
        logic       clr;
        int         e_cnt;
        logic       e_ov;
        logic       e_ir;
        logic       chk;
        logic [1:0] e_op;
        logic [3:0] e_res;
        logic       e_c;
        logic       e_z;
        logic       e_sc;
        logic       e_sz;
        int         e_acc;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [1:0] op,
                         input logic [3:0] res, input logic c, input logic z,
                         input logic ordy, input logic clr);
        rst              = r;
        bus.in_valid     = iv;
        bus.in_op        = op;
        bus.in_result    = res;
        bus.in_carry     = c;
        bus.in_zero      = z;
        bus.out_ready    = ordy;
        bus.clear_sticky = clr;
    endtask

    // Advance one clock, update the model from the inputs that were applied,
    // then compare DUT state against the model.
    task automatic tick();
        logic       r, m_push, m_pop, c, z, clr;
        logic [7:0] ent;
        logic [7:0] hd;
        r      = rst;
        m_push = bus.in_valid && (mq.size() < DEPTH);
        m_pop  = bus.out_ready && (mq.size() > 0);
        c      = bus.in_carry;
        z      = bus.in_zero;
        clr    = bus.clear_sticky;
        ent    = {bus.in_op, bus.in_carry, bus.in_zero, bus.in_result};
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            m_sc  = 1'b0;
            m_sz  = 1'b0;
            m_acc = 0;
        end else begin
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back(ent);
            m_sc = (m_sc & ~clr) | (m_push & c);
            m_sz = (m_sz & ~clr) | (m_push & z);
            if (m_push) m_acc = (m_acc + 1) % 256;
        end
        check("m_count",     int'(bus.count),        mq.size());
        check("m_in_ready",  int'(bus.in_ready),     int'(mq.size() < DEPTH));
        check("m_out_valid", int'(bus.out_valid),    int'(mq.size() > 0));
        check("m_sticky_c",  int'(bus.sticky_carry), int'(m_sc));
        check("m_sticky_z",  int'(bus.sticky_zero),  int'(m_sz));
        check("m_accepted",  int'(bus.accepted),     m_acc);
        if (mq.size() > 0) begin
            hd = mq[0];
            check("m_out_op",     int'(bus.out_op),     int'(hd[7:6]));
            check("m_out_carry",  int'(bus.out_carry),  int'(hd[5]));
            check("m_out_zero",   int'(bus.out_zero),   int'(hd[4]));
            check("m_out_result", int'(bus.out_result), int'(hd[3:0]));
        end
    endtask

    function automatic vec_t mk(
        logic r, logic iv, logic [1:0] op, logic [3:0] res, logic c, logic z,
        logic ordy, logic clr, int e_cnt, logic e_ov, logic e_ir, logic chk,
        logic [1:0] e_op, logic [3:0] e_res, logic e_c, logic e_z,
        logic e_sc, logic e_sz, int e_acc);
        vec_t v;
        v.rst = r; v.iv = iv; v.op = op; v.res = res; v.c = c; v.z = z;
        v.ordy = ordy; v.clr = clr; v.e_cnt = e_cnt; v.e_ov = e_ov;
        v.e_ir = e_ir; v.chk = chk; v.e_op = e_op; v.e_res = e_res;
        v.e_c = e_c; v.e_z = e_z; v.e_sc = e_sc; v.e_sz = e_sz; v.e_acc = e_acc;
        return v;
    endfunction

    initial begin
        m_sc  = 1'b0;
        m_sz  = 1'b0;
        m_acc = 0;
        drive(1, 0, 2'b00, 4'h0, 0, 0, 0, 0);

        //           rst iv op     res   c  z  ordy clr | cnt ov ir chk op  res   c  z  sc sz acc
        vt.push_back(mk(0, 0, 2'b00, 4'h0, 0, 0, 0, 0,   0, 0, 1, 1, 2'b00, 4'h0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 2'b00, 4'h0, 1, 1, 0, 0,   1, 1, 1, 1, 2'b00, 4'h0, 1, 1, 1, 1, 1));
        vt.push_back(mk(0, 0, 2'b00, 4'h0, 0, 0, 1, 0,   0, 0, 1, 0, 2'b00, 4'h0, 0, 0, 1, 1, 1));
        vt.push_back(mk(0, 0, 2'b00, 4'h0, 0, 0, 0, 1,   0, 0, 1, 0, 2'b00, 4'h0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 1, 2'b01, 4'h3, 0, 0, 0, 0,   1, 1, 1, 1, 2'b01, 4'h3, 0, 0, 0, 0, 2));
        vt.push_back(mk(0, 1, 2'b10, 4'h5, 0, 0, 0, 0,   2, 1, 1, 1, 2'b01, 4'h3, 0, 0, 0, 0, 3));
        vt.push_back(mk(0, 1, 2'b11, 4'hE, 1, 0, 0, 0,   3, 1, 1, 1, 2'b01, 4'h3, 0, 0, 1, 0, 4));
        vt.push_back(mk(0, 1, 2'b00, 4'h1, 0, 0, 0, 0,   4, 1, 0, 1, 2'b01, 4'h3, 0, 0, 1, 0, 5));
        vt.push_back(mk(0, 1, 2'b10, 4'h9, 0, 0, 0, 0,   4, 1, 0, 1, 2'b01, 4'h3, 0, 0, 1, 0, 5));
        vt.push_back(mk(0, 1, 2'b10, 4'h9, 0, 0, 1, 0,   3, 1, 1, 1, 2'b10, 4'h5, 0, 0, 1, 0, 5));
        vt.push_back(mk(0, 1, 2'b10, 4'h9, 0, 0, 0, 0,   4, 1, 0, 1, 2'b10, 4'h5, 0, 0, 1, 0, 6));
        vt.push_back(mk(0, 0, 2'b00, 4'h0, 0, 0, 1, 0,   3, 1, 1, 1, 2'b11, 4'hE, 1, 0, 1, 0, 6));
        vt.push_back(mk(0, 0, 2'b00, 4'h0, 0, 0, 1, 0,   2, 1, 1, 1, 2'b00, 4'h1, 0, 0, 1, 0, 6));
        vt.push_back(mk(0, 0, 2'b00, 4'h0, 0, 0, 1, 0,   1, 1, 1, 1, 2'b10, 4'h9, 0, 0, 1, 0, 6));
        vt.push_back(mk(0, 0, 2'b00, 4'h0, 0, 0, 1, 0,   0, 0, 1, 0, 2'b00, 4'h0, 0, 0, 1, 0, 6));
        vt.push_back(mk(0, 0, 2'b00, 4'h0, 0, 0, 0, 1,   0, 0, 1, 0, 2'b00, 4'h0, 0, 0, 0, 0, 6));
        vt.push_back(mk(0, 1, 2'b00, 4'h2, 1, 0, 0, 1,   1, 1, 1, 1, 2'b00, 4'h2, 1, 0, 1, 0, 7));
        vt.push_back(mk(0, 0, 2'b00, 4'h0, 0, 0, 1, 1,   0, 0, 1, 0, 2'b00, 4'h0, 0, 0, 0, 0, 7));
        vt.push_back(mk(0, 1, 2'b01, 4'h4, 0, 0, 0, 0,   1, 1, 1, 1, 2'b01, 4'h4, 0, 0, 0, 0, 8));
        vt.push_back(mk(0, 1, 2'b01, 4'h6, 0, 0, 0, 0,   2, 1, 1, 1, 2'b01, 4'h4, 0, 0, 0, 0, 9));
        vt.push_back(mk(0, 1, 2'b01, 4'h7, 0, 0, 0, 0,   3, 1, 1, 1, 2'b01, 4'h4, 0, 0, 0, 0, 10));
        vt.push_back(mk(1, 1, 2'b01, 4'hF, 1, 1, 1, 0,   0, 0, 1, 1, 2'b00, 4'h0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 2'b11, 4'h8, 0, 1, 0, 0,   1, 1, 1, 1, 2'b11, 4'h8, 0, 1, 0, 1, 1));

        // Reset for a few cycles, then walk the directed table.
        repeat (3) tick();
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].iv, vt[i].op, vt[i].res, vt[i].c, vt[i].z,
                  vt[i].ordy, vt[i].clr);
            tick();
            check($sformatf("v%0d_count", i),     int'(bus.count),        vt[i].e_cnt);
            check($sformatf("v%0d_out_valid", i), int'(bus.out_valid),    int'(vt[i].e_ov));
            check($sformatf("v%0d_in_ready", i),  int'(bus.in_ready),     int'(vt[i].e_ir));
            check($sformatf("v%0d_sticky_c", i),  int'(bus.sticky_carry), int'(vt[i].e_sc));
            check($sformatf("v%0d_sticky_z", i),  int'(bus.sticky_zero),  int'(vt[i].e_sz));
            check($sformatf("v%0d_accepted", i),  int'(bus.accepted),     vt[i].e_acc);
            if (vt[i].chk) begin
                check($sformatf("v%0d_out_op", i),     int'(bus.out_op),     int'(vt[i].e_op));
                check($sformatf("v%0d_out_result", i), int'(bus.out_result), int'(vt[i].e_res));
                check($sformatf("v%0d_out_carry", i),  int'(bus.out_carry),  int'(vt[i].e_c));
                check($sformatf("v%0d_out_zero", i),   int'(bus.out_zero),   int'(vt[i].e_z));
            end
        end

        // Steady-state stream: one push, then 299 cycles of push+pop.
        drive(1, 0, 2'b00, 4'h0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 0, 0);
        tick();
        for (int i = 0; i < 299; i++) begin
            drive(0, 1, 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1, 0);
            tick();
            check("stream_count", int'(bus.count), 1);
        end
        check("stream_accepted_wrap", int'(bus.accepted), 44);

        // Fully random traffic with occasional clears and resets.
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0),
                  2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered output stage directly downstream of the 4-bit combinational ALU (`simple_alu_4bit`). It captures each ALU response (result, carry_out, zero), tags it with the opcode that produced it, and holds it in a small first-in-first-out buffer. Consumers drain the buffer through a valid/ready handshake. The block also keeps sticky carry/zero status flags and a count of accepted operations, so a controller can poll them without draining the queue.

## Interface
- DEPTH, 4, number of buffer entries; power of two, ≥ 2
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden)
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  ALU response present this cycle
- in_ready  output  1  buffer can accept; equals (count < DEPTH)
- in_op  input  2  opcode that produced the response
- in_result  input  4  ALU result
- in_carry  input  1  ALU carry_out
- in_zero  input  1  ALU zero flag
- out_valid  output  1  head entry present; equals (count != 0)
- out_ready  input  1  consumer takes the head entry this cycle
- out_op / out_result / out_carry / out_zero  output  2/4/1/1  head entry fields
- count  output  CW  current occupancy, 0..DEPTH
- sticky_carry  output  1  set by any accepted entry with carry = 1
- sticky_zero  output  1  set by any accepted entry with zero = 1
- clear_sticky  input  1  clears both sticky flags
- accepted  output  8  total entries accepted since reset; wraps 255 → 0

## Operation
- Push: in_valid && in_ready writes {op, carry, zero, result} at the write pointer. The write pointer advances modulo DEPTH.
- Pop: out_valid && out_ready advances the read pointer modulo DEPTH.
- Output data: the out_* fields read combinationally from the entry at the read pointer.
- Output data when empty: out_* fields are undefined but must not be X in simulation; drive entry contents, with storage reset to 0.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full: in_ready = 0, so no push, even if a pop occurs in the same cycle (no full-pass-through). in_ready rises the cycle after the pop.
- Empty: out_valid = 0. There is no combinational bypass from input to output.
- Simultaneous push and pop at 0 < count < DEPTH: both happen and count is unchanged.
- Sticky flags: next = (flag & ~clear_sticky) | (push & field). A set in the same cycle as clear_sticky wins, so a new event is never lost.
- accepted increments on every push and wraps at 8 bits.
- The block never modifies or checks data: an inconsistent in_zero is stored as given.
- Reset mid-operation: all entries are discarded immediately, with no drain.

## Timing
- Reset values:
  - count = 0, in_ready = 1, out_valid = 0
  - pointers = 0, storage = 0, so out_* = 0
  - sticky_carry = 0, sticky_zero = 0, accepted = 0
- Latency: an entry pushed in cycle N is visible at the output (out_valid = 1) in cycle N+1.
- Throughput: one push and one pop per cycle in steady state.
- in_ready and out_valid depend only on registered state, never on in_valid or out_ready.
- While rst = 1, handshake inputs are ignored. The first accepted push is in the first cycle with rst = 0.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_XOR = 2'b11
  - packed struct alu_resp_t {op[1:0], carry, zero, result[3:0]} (8 bits), used for storage and by other consumers
- Storage is an array of alu_resp_t. Pointers and count are kept inline.
- No sub-module. The block is small enough to remain single-module.

## Test plan
- Reset then idle → in_ready = 1, out_valid = 0, count = 0, all flags 0, accepted = 0.
- Push ADD response {result = 0, carry = 1, zero = 1} (from 9 + 7) with out_ready = 0 → next cycle:
  - out_valid = 1, out_result = 0, out_carry = 1, out_zero = 1, out_op = 00
  - count = 1, sticky_carry = 1, sticky_zero = 1, accepted = 1
- Push 4 responses (results 3, 5, 0xE, 1) with out_ready = 0 → count = 4, in_ready = 0. A 5th in_valid is not accepted. Draining yields 3, 5, 0xE, 1 in order; count returns to 0.
- Full buffer, in_valid = 1 and out_ready = 1 in the same cycle → pop only. count goes 4 → 3; the new entry is accepted the following cycle.
- Continuous push and pop with random values for 300 cycles → output order matches a scoreboard, count stays 1, accepted wraps to 300 − 256 = 44.
- Assert clear_sticky in the same cycle as a push with carry = 1 → sticky_carry = 1 next cycle. clear_sticky alone → sticky_carry = 0. rst mid-fill with count = 3 → count = 0, out_valid = 0 next cycle.
